if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch front end that produces the IF-stage outputs consumed by the IF/ID pipeline register. It holds the PC and issues in-order requests to instruction memory over a request/grant/response interface. Returned words are buffered in a small fetch queue and presented on `instr_if`/`instr_addr_if`. The block honours the pipeline's `stall_n` and `flush` controls, redirecting to a new PC on flush and discarding in-flight responses from the old path.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `FQ_DEPTH`, default 4: fetch-queue entries. Must be a power of two, ≥2. Also bounds the number of outstanding requests.

- `clk` in 1: single clock, all state on the rising edge.
- `rst_sync` in 1: synchronous, active-high reset.
- `stall_n` in 1: 1 = decode consumes the current instruction this cycle; 0 = hold.
- `flush` in 1: pipeline redirect, fetch restarts at `redirect_pc`.
- `redirect_pc` in 32: target address, sampled when `flush`=1.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_gnt` in 1: memory accepts the request this cycle (`imem_req && imem_gnt`).
- `imem_rvalid` in 1: response valid. Responses arrive in request order, ≥1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `instr_if` out 32: instruction to IF/ID. Equals `INST_NOP` when `instr_valid_if`=0.
- `instr_addr_if` out 32: address of `instr_if`. Equals 0 when invalid.
- `instr_valid_if` out 1: queue head is filled.

## Operation
- **PC.** `pc_q` resets to `RESET_PC`. It advances by 4 on each grant. On `flush`, `pc_q` loads `{redirect_pc[31:2],2'b00}`.
- **Request.** `imem_req` = !rst_sync && !flush && (alloc_cnt < FQ_DEPTH) && (outstanding_q < FQ_DEPTH), with `imem_addr` = `pc_q`.
  - `imem_req` does not depend on `stall_n`.
  - Once asserted, `imem_req`/`imem_addr` stay stable until granted, unless `flush` or reset intervenes.
- **Queue.** Each grant allocates the tail entry: the address is stored and the entry is marked unfilled.
  - A non-dropped `imem_rvalid` fills the oldest unfilled entry with `imem_rdata`.
  - The head is presented when it is filled.
  - Pop happens when `stall_n && instr_valid_if`.
  - `alloc_cnt` counts allocated entries, filled or not.
- **Outstanding.** `outstanding_q` is +1 per grant and −1 per `imem_rvalid` (including dropped responses).
- **Flush.**
  - All queue entries are invalidated.
  - `drop_q` <= `outstanding_q` − `imem_rvalid`.
  - Afterwards, each `imem_rvalid` while `drop_q`>0 decrements `drop_q` and writes nothing.
  - Fetch restarts at the redirect PC in the next cycle.
- **Precedence.** `rst_sync` > `flush` > pop/fill/grant.
  - A flush in the same cycle as pop or `imem_rvalid`: the pop is ignored, and the response is dropped (it is not counted in the new `drop_q`).
  - Flush while `drop_q`>0: `drop_q` is recomputed from `outstanding_q`, which already covers the older in-flight responses.
- **Reset.** Sets `pc_q`=RESET_PC and empties the queue; `alloc_cnt`=0, `outstanding_q`=0, `drop_q`=0.
  - Outputs during and after reset, until the first fill: `imem_req`=0 during the reset cycle; `instr_valid_if`=0, `instr_if`=INST_NOP, `instr_addr_if`=0.
  - Responses for requests in flight at reset are not tracked. The memory side is reset by the same `rst_sync`.
- **Fill while empty.** A fill into an empty queue is visible at the outputs the following cycle. There is no combinational bypass.

## Timing
- Memory with `imem_gnt`=1 and 1-cycle response latency, reset released before cycle 0:
  - Cycle 0: request for RESET_PC.
  - Cycle 1: rvalid.
  - Cycle 2: `instr_valid_if`=1 with `instr_addr_if`=RESET_PC.
- Steady state with `stall_n`=1 and FQ_DEPTH≥4: one instruction per cycle.
- Stall: outputs remain stable while `stall_n`=0. Requests continue until `alloc_cnt`=FQ_DEPTH.
- Flush in cycle N:
  - First request to the new PC in cycle N+1.
  - Earliest valid output in cycle N+3 (1-cycle memory).
  - `instr_valid_if`=0 from cycle N+1 until then.
- Pointers are log2(FQ_DEPTH) bits and wrap naturally. Counters are log2(FQ_DEPTH)+1 bits.

## Structure
- `RV32I_Inst_Pkg` supplies `INST_NOP`.
- Add `IF_FQ_DEPTH_DEFAULT` and a `fq_entry_t` struct {`addr[31:0]`, `instr[31:0]`, `filled`} to that package.
- Sub-module `if_fetch_queue`: circular buffer with alloc/fill/pop/clear ports plus `head_valid` and `count`.
- `if_fetch_unit` owns the PC, request logic, outstanding/drop counters and output muxing.

## Test plan
- Reset, then `imem_gnt`=1 with 1-cycle memory and `stall_n`=1 → addresses 0,4,8,C appear on consecutive cycles starting cycle 2; `instr_if` matches memory.
- `stall_n`=0 for 6 cycles mid-stream → outputs frozen at the same address; `imem_req` drops after 4 allocations; resumes without loss or duplication.
- Flush to 0x100 with 2 requests outstanding and a 3-cycle memory → both stale responses are dropped; the next valid output is 0x100, then 0x104.
- Flush coincident with `imem_rvalid` and pop → response discarded; no queue write; `drop_q` = outstanding−1.
- `imem_gnt` toggling randomly (0,0,1,0,1) → `imem_addr` is held stable while ungranted; output sequence stays contiguous.
- Assert `rst_sync` mid-stream with a full queue → the next cycle shows `instr_valid_if`=0, `instr_if`=INST_NOP, `instr_addr_if`=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/RV32I_Inst_Pkg.sv
// Shared RV32I constants and the fetch-queue entry type used by the IF stage.
package RV32I_Inst_Pkg;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int IF_FQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        filled;
    } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Circular fetch buffer: entries are allocated at grant, filled in order by
// responses, and popped from the head once filled.
module if_fetch_queue
    import RV32I_Inst_Pkg::*;
#(
    parameter int DEPTH = IF_FQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_sync,
    input  logic                     clear,
    input  logic                     alloc,
    input  logic [31:0]              alloc_addr,
    input  logic                     fill,
    input  logic [31:0]              fill_data,
    input  logic                     pop,
    output logic [31:0]              head_addr,
    output logic [31:0]              head_instr,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t              entries_q [DEPTH];
    fq_entry_t              head_entry;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [PTR_W-1:0]       fill_q, fill_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   pop_en;

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        head_entry = entries_q[head_q];
        head_valid = (count_q != '0) && head_entry.filled;
        pop_en     = pop && head_valid;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            fill_d  = '0;
            count_d = '0;
        end else begin
            if (alloc)  tail_d = tail_q + PTR_W'(1);
            if (fill)   fill_d = fill_q + PTR_W'(1);
            if (pop_en) head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(alloc) - CNT_W'(pop_en);
        end
        head_addr  = head_entry.addr;
        head_instr = head_entry.instr;
        count      = count_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry storage has no reset; count_q gates head_valid and an
    // entry's filled bit is rewritten at allocation, so stale contents are
    // never observed.
    always_ff @(posedge clk) begin
        if (alloc && !clear) begin
            entries_q[tail_q] <= '{addr: alloc_addr, instr: 32'h0, filled: 1'b0};
        end
        if (fill && !clear) begin
            entries_q[fill_q].instr  <= fill_data;
            entries_q[fill_q].filled <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage front end: PC, in-order imem requests, outstanding/drop tracking
// and the IF/ID-facing outputs taken from the fetch-queue head.
module if_fetch_unit
    import RV32I_Inst_Pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = IF_FQ_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        stall_n,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_if,
    output logic [31:0] instr_addr_if,
    output logic        instr_valid_if
);

    localparam int               CNT_W     = $clog2(FQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FQ_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] alloc_cnt;
    logic             grant, drop_rsp;
    logic             fq_clear, fq_fill, fq_pop;
    logic             head_valid;
    logic [31:0]      head_addr, head_instr;

    always_comb begin
        imem_req  = !rst_sync && !flush && (alloc_cnt < DEPTH_CNT)
                    && (outstanding_q < DEPTH_CNT);
        imem_addr = pc_q;
        grant     = imem_req && imem_gnt;
        drop_rsp  = imem_rvalid && (drop_q != '0);
        fq_clear  = rst_sync || flush;
        fq_fill   = imem_rvalid && !drop_rsp && !fq_clear;
        fq_pop    = stall_n && head_valid && !fq_clear;

        pc_d          = pc_q;
        drop_d        = drop_q;
        // No grant can coincide with flush, so this also holds on redirect.
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
        if (flush) begin
            pc_d   = redirect_pc & ~32'h3;
            drop_d = outstanding_q - CNT_W'(imem_rvalid);
        end else begin
            if (grant)    pc_d   = pc_q + 32'd4;
            if (drop_rsp) drop_d = drop_q - CNT_W'(1);
        end

        instr_valid_if = head_valid;
        instr_if       = head_valid ? head_instr : INST_NOP;
        instr_addr_if  = head_valid ? head_addr : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    if_fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_sync   (rst_sync),
        .clear      (fq_clear),
        .alloc      (grant),
        .alloc_addr (pc_q),
        .fill       (fq_fill),
        .fill_data  (imem_rdata),
        .pop        (fq_pop),
        .head_addr  (head_addr),
        .head_instr (head_instr),
        .head_valid (head_valid),
        .count      (alloc_cnt)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model with programmable latency,
// a stream-level reference model checked every cycle, and directed scenarios.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        rst_sync;
    logic        stall_n;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_if;
    logic [31:0] instr_addr_if;
    logic        instr_valid_if;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_sync       (rst_sync),
        .stall_n        (stall_n),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_if       (instr_if),
        .instr_addr_if  (instr_addr_if),
        .instr_valid_if (instr_valid_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // ---------------- memory: in-order responses, lat cycles after grant
    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t mem_q[$];
    int   cyc = 0;
    int   lat = 1;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int due;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            if (rst_sync) begin
                mem_q.delete();
            end else begin
                if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
                if (imem_req && imem_gnt) begin
                    due = cyc + lat;
                    if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
                    mem_q.push_back('{addr: imem_addr, due: due});
                end
            end
            #1;
            if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_q[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // ---------------- stream model: the next address decode must see
    bit          model_ok = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    int          held = 0;
    bit          prev_hold = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_req_addr = 32'h0;
    logic [31:0] prev_out_addr = 32'h0;
    logic [31:0] prev_out_instr = 32'h0;

    always @(posedge clk) begin
        if (rst_sync) begin
            exp_addr <= RESET_PC;
            held     <= 0;
            model_ok <= 1'b1;
        end else if (model_ok) begin
            if (flush) begin
                exp_addr <= redirect_pc & ~32'h3;
                held     <= 0;
            end else begin
                if (instr_valid_if && stall_n) exp_addr <= exp_addr + 32'd4;
                held <= held + int'(imem_req && imem_gnt) - int'(instr_valid_if && stall_n);
            end
        end
        prev_hold      <= imem_req && !imem_gnt && !flush && !rst_sync;
        prev_req_addr  <= imem_addr;
        prev_stall     <= instr_valid_if && !stall_n && !flush && !rst_sync;
        prev_out_addr  <= instr_addr_if;
        prev_out_instr <= instr_if;
    end

    always @(negedge clk) begin
        if (model_ok && rst_sync) begin
            check("rst_req", 32'(imem_req), 32'h0);
        end else if (model_ok) begin
            if (instr_valid_if) begin
                check("out_addr", instr_addr_if, exp_addr);
                check("out_instr", instr_if, mem_word(exp_addr));
            end else begin
                check("idle_instr", instr_if, 32'h0000_0013);
                check("idle_addr", instr_addr_if, 32'h0);
            end
            if (imem_req) check("req_align", 32'(imem_addr[1:0]), 32'h0);
            if (prev_hold && !flush) begin
                check("req_held", 32'(imem_req), 32'h1);
                check("req_addr_held", imem_addr, prev_req_addr);
            end
            if (prev_stall) begin
                check("stall_valid", 32'(instr_valid_if), 32'h1);
                check("stall_addr", instr_addr_if, prev_out_addr);
                check("stall_instr", instr_if, prev_out_instr);
            end
            check("fq_bound", 32'(held <= DEPTH), 32'h1);
            if (held >= DEPTH) check("fq_full_req", 32'(imem_req), 32'h0);
        end
    end

    task automatic wait_valid(input int max_cycles, input string name);
        int n = 0;
        while (!instr_valid_if && n < max_cycles) begin
            tick();
            sample();
            n++;
        end
        check(name, 32'(instr_valid_if), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios
    logic [31:0] first_seq [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] gnt_pat   [5] = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h1};
    logic [31:0] gnt_addr  [5] = '{32'h400, 32'h400, 32'h400, 32'h404, 32'h404};
    int          exp_drop;

    initial begin
        rst_sync    = 1'b1;
        stall_n     = 1'b1;
        flush       = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b1;
        tick();
        tick();
        rst_sync = 1'b0;

        // cycle 0: request for RESET_PC, nothing presented yet
        sample();
        check("c0_req", 32'(imem_req), 32'h1);
        check("c0_addr", imem_addr, RESET_PC);
        check("c0_valid", 32'(instr_valid_if), 32'h0);
        tick();
        sample();
        check("c1_no_bypass", 32'(instr_valid_if), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            sample();
            check("stream_valid", 32'(instr_valid_if), 32'h1);
            check("stream_addr", instr_addr_if, first_seq[i]);
            if (i == 0) check("first_instr", instr_if, 32'hC0DE_0000);
        end

        // six-cycle stall: frozen at 0x10, requests stop once 4 are allocated
        tick();
        stall_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample();
            check("stall_hold_addr", instr_addr_if, 32'h10);
            if (i < 5) tick();
        end
        check("stall_full_req", 32'(imem_req), 32'h0);
        tick();
        stall_n = 1'b1;
        sample();
        check("resume_addr0", instr_addr_if, 32'h10);
        tick();
        sample();
        check("resume_addr1", instr_addr_if, 32'h14);
        for (int i = 0; i < 4; i++) tick();

        // flush with a 1-cycle memory, coincident with rvalid and pop
        flush       = 1'b1;
        redirect_pc = 32'h200;
        sample();
        check("flushA_req", 32'(imem_req), 32'h0);
        tick();
        flush = 1'b0;
        sample();
        check("flushA_n1_req", 32'(imem_req), 32'h1);
        check("flushA_n1_addr", imem_addr, 32'h200);
        check("flushA_n1_valid", 32'(instr_valid_if), 32'h0);
        check("flushA_drop", 32'(dut.drop_q), 32'h0);
        tick();
        sample();
        check("flushA_n2_valid", 32'(instr_valid_if), 32'h0);
        tick();
        sample();
        check("flushA_n3_valid", 32'(instr_valid_if), 32'h1);
        check("flushA_n3_addr", instr_addr_if, 32'h200);
        check("flushA_n3_instr", instr_if, 32'hC0DE_0200);

        // 2-cycle memory: flush meets a response and a pop in the same cycle
        lat = 2;
        for (int i = 0; i < 8; i++) tick();
        flush       = 1'b1;
        redirect_pc = 32'h302;
        sample();
        check("coinc_setup", 32'(instr_valid_if && imem_rvalid), 32'h1);
        exp_drop = mem_q.size() - int'(imem_rvalid);
        tick();
        flush = 1'b0;
        sample();
        check("coinc_drop_model", 32'(dut.drop_q), 32'(exp_drop));
        check("coinc_drop_lit", 32'(dut.drop_q), 32'h1);
        check("coinc_redirect_addr", imem_addr, 32'h300);
        wait_valid(10, "coinc_timeout");
        check("coinc_first", instr_addr_if, 32'h300);
        tick();
        sample();
        check("coinc_second", instr_addr_if, 32'h304);

        // 3-cycle memory: drain, two grants, flush with both in flight
        lat      = 3;
        imem_gnt = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        imem_gnt = 1'b1;
        tick();
        tick();
        flush       = 1'b1;
        redirect_pc = 32'h100;
        tick();
        flush = 1'b0;
        sample();
        check("flushC_drop", 32'(dut.drop_q), 32'h2);
        wait_valid(12, "flushC_timeout");
        check("flushC_first", instr_addr_if, 32'h100);
        tick();
        sample();
        check("flushC_second_valid", 32'(instr_valid_if), 32'h1);
        check("flushC_second", instr_addr_if, 32'h104);

        // grant pattern 0,0,1,0,1 after redirecting to a known PC
        lat = 1;
        for (int i = 0; i < 4; i++) tick();
        flush       = 1'b1;
        redirect_pc = 32'h400;
        for (int i = 0; i < 5; i++) begin
            tick();
            flush    = 1'b0;
            imem_gnt = gnt_pat[i][0];
            sample();
            check("gnt_req", 32'(imem_req), 32'h1);
            check("gnt_addr", imem_addr, gnt_addr[i]);
        end
        tick();
        imem_gnt = 1'b1;
        sample();
        check("gnt_after_addr", imem_addr, 32'h408);
        for (int i = 0; i < 6; i++) tick();

        // reset mid-stream with a full queue
        stall_n = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        sample();
        check("prerst_full_req", 32'(imem_req), 32'h0);
        check("prerst_valid", 32'(instr_valid_if), 32'h1);
        tick();
        rst_sync = 1'b1;
        stall_n  = 1'b1;
        sample();
        check("rst_cycle_req", 32'(imem_req), 32'h0);
        tick();
        rst_sync = 1'b0;
        sample();
        check("postrst_valid", 32'(instr_valid_if), 32'h0);
        check("postrst_instr", instr_if, 32'h0000_0013);
        check("postrst_addr", instr_addr_if, 32'h0);
        check("postrst_req", 32'(imem_req), 32'h1);
        check("postrst_req_addr", imem_addr, RESET_PC);
        tick();
        tick();
        sample();
        check("postrst_first_valid", 32'(instr_valid_if), 32'h1);
        check("postrst_first_addr", instr_addr_if, RESET_PC);
        for (int i = 0; i < 4; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
